// File: rtl/reqack_pkg.sv
// reqack_pkg: shared FSM state type and default sizing for the req/ack arbiter and its checker.
package reqack_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} reqack_state_e;
  localparam int DEF_N = 3;
  localparam int DEF_MAX_HOLD = 5;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   [N]  : candidate requests
//   last  [IW] : previously granted index; search starts at (last+1) mod N
//   valid      : any request present
//   idx   [IW] : first set request found searching upward with wrap
module rr_pick #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid = |req;
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = IW'((int'(last) + k) % N);
  end
endmodule

// File: rtl/reqack_arb_n.sv
// reqack_arb_n: N-channel round-robin req/ack arbiter with hold watchdog.
//   clk, reset_n      : clock and asynchronous active-low reset
//   enb               : global enable; low freezes IDLE/GRANT state and hold counter
//   req/done/intrpt   : per-channel request, release and abort (done/intrpt honoured for granted channel only)
//   err_clr           : synchronous clear of sticky timeout flags
//   ack/busy/grant_id : registered one-hot grant, grant-active flag, current/last granted index
//   timeout           : sticky per-channel watchdog flags
module reqack_arb_n import reqack_pkg::*; #(
  parameter int N = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int CW = $clog2(MAX_HOLD + 1),
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enb,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  input  logic [N-1:0]  intrpt,
  input  logic          err_clr,
  output logic [N-1:0]  ack,
  output logic          busy,
  output logic [IW-1:0] grant_id,
  output logic [N-1:0]  timeout
);
  reqack_state_e state_q, state_d;
  logic [N-1:0] ack_q, ack_d, timeout_q, timeout_d;
  logic busy_q, busy_d;
  logic [IW-1:0] grant_id_q, grant_id_d, last_q, last_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic pick_valid, grant, rel, expired, user_rel;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N)) u_pick (.req(req), .last(last_q), .valid(pick_valid), .idx(pick_idx));

  assign grant = enb && state_q == IDLE && pick_valid;
  assign user_rel = intrpt[grant_id_q] || done[grant_id_q];
  assign expired = hold_cnt_q == CW'(MAX_HOLD - 1);
  assign rel = enb && state_q == GRANT && (user_rel || expired);

  // Watchdog flag is set only when neither done nor intrpt released the grant; set wins over err_clr.
  always_comb begin
    state_d = grant ? GRANT : rel ? RELEASE : (state_q == IDLE || state_q == GRANT) ? state_q : IDLE;
    ack_d = grant ? N'(1) << pick_idx : rel ? '0 : ack_q;
    busy_d = grant || (busy_q && !rel);
    grant_id_d = grant ? pick_idx : grant_id_q;
    last_d = rel ? grant_id_q : last_q;
    hold_cnt_d = grant ? '0 : (enb && state_q == GRANT && !rel) ? hold_cnt_q + CW'(1) : hold_cnt_q;
    timeout_d = (err_clr ? '0 : timeout_q) | ((rel && !user_rel) ? N'(1) << grant_id_q : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack_q <= '0;
      busy_q <= 1'b0;
      grant_id_q <= '0;
      last_q <= IW'(N - 1);
      hold_cnt_q <= '0;
      timeout_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      grant_id_q <= grant_id_d;
      last_q <= last_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack = ack_q;
  assign busy = busy_q;
  assign grant_id = grant_id_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_reqack_arb_n.sv
// tb_reqack_arb_n: scoreboard bench for reqack_arb_n with a phase-level reference model.
module tb_reqack_arb_n;
  localparam int N = 3;
  localparam int MAX_HOLD = 5;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [N-1:0]  ack;
    logic          busy;
    logic [IW-1:0] gid;
    logic [N-1:0]  to;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enb = 1'b1;
  logic [N-1:0] req = '0, done = '0, intrpt = '0;
  logic err_clr = 1'b0;
  logic [N-1:0] ack, timeout;
  logic busy;
  logic [IW-1:0] grant_id;

  int checks = 0;
  int errors = 0;
  int run = 0;
  int last_run = 0;
  exp_t q[$];

  reqack_arb_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .enb(enb), .req(req), .done(done), .intrpt(intrpt),
    .err_clr(err_clr), .ack(ack), .busy(busy), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = granted to owner, 2 = dead cycle.
  // held counts enabled clock edges spent granted; MAX_HOLD of them forces release.
  initial begin
    int phase, owner, held, lastc;
    bit found;
    logic [N-1:0] to_m, setm;
    exp_t e;
    phase = 0; owner = 0; held = 0; lastc = N - 1; to_m = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        phase = 0; owner = 0; held = 0; lastc = N - 1; to_m = '0;
        q.delete();
        e.ack = '0; e.busy = 1'b0; e.gid = '0; e.to = '0;
        q.push_back(e);
      end else begin
        setm = '0;
        if (phase == 2) phase = 0;
        else if (phase == 0) begin
          if (enb && req != '0) begin
            found = 0;
            for (int k = 1; k <= N; k++)
              if (!found && req[(lastc + k) % N]) begin
                owner = (lastc + k) % N;
                found = 1;
              end
            held = 0;
            phase = 1;
          end
        end else if (enb) begin
          held++;
          if (intrpt[owner] || done[owner]) begin
            phase = 2;
            lastc = owner;
          end else if (held == MAX_HOLD) begin
            setm[owner] = 1'b1;
            phase = 2;
            lastc = owner;
          end
        end
        to_m = (err_clr ? '0 : to_m) | setm;
        e.ack = (phase == 1) ? N'(1) << owner : '0;
        e.busy = phase == 1;
        e.gid = IW'(owner);
        e.to = to_m;
        q.push_back(e);
      end
    end
  end

  // Monitor: every falling edge the DUT presents its outputs; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        if (reset_n) begin
          errors++;
          $display("FAIL scoreboard_underflow at %0t: got empty queue expected one entry", $time);
        end
      end else begin
        e = q.pop_front();
        chk("ack", int'(ack), int'(e.ack));
        chk("busy", int'(busy), int'(e.busy));
        chk("grant_id", int'(grant_id), int'(e.gid));
        chk("timeout", int'(timeout), int'(e.to));
      end
      if (ack != '0) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; done = '0; intrpt = '0; enb = 1'b1; err_clr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    run = 0;
  endtask

  task automatic wait_ack(input bit hi);
    int n = 0;
    while (((ack != '0) != hi) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_ack at %0t: got ack %0h expected level %0d within 50 cycles", $time, ack, hi);
    end
  endtask

  initial begin
    int exp_ids[4] = '{0, 1, 2, 0};
    step();
    do_reset();
    // Single request released by done one cycle after ack.
    req = 3'b001;
    step();
    chk("single_ack", int'(ack), 1);
    req = '0; done = 3'b001;
    step();
    done = '0;
    chk("single_rel", int'(ack), 0);
    step();
    chk("single_dead", int'(ack), 0);
    step();
    chk("single_len", last_run, 1);
    chk("single_to", int'(timeout), 0);
    // Round-robin with all requests held.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b1);
      chk("rr_id", int'(grant_id), exp_ids[i]);
      chk("rr_ack", int'(ack), 1 << exp_ids[i]);
      done = ack;
      step();
      done = '0;
    end
    req = '0;
    step(); step();
    // Watchdog expiry and sticky clear.
    do_reset();
    req = 3'b010;
    step();
    req = '0;
    wait_ack(1'b0);
    step();
    chk("wd_len", last_run, MAX_HOLD);
    chk("wd_to", int'(timeout), 3'b010);
    step(); step(); step();
    chk("wd_sticky", int'(timeout), 3'b010);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd_clear", int'(timeout), 0);
    // intrpt and done together release without error; foreign done ignored.
    do_reset();
    req = 3'b100;
    step();
    req = '0;
    chk("pri_ack", int'(ack), 3'b100);
    intrpt = 3'b100; done = 3'b100;
    step();
    intrpt = '0; done = '0;
    chk("pri_rel", int'(ack), 0);
    chk("pri_to", int'(timeout), 0);
    step(); step();
    req = 3'b100;
    step();
    req = '0; done = 3'b001;
    step(); step();
    chk("ign_done", int'(ack), 3'b100);
    done = 3'b100;
    step();
    done = '0;
    chk("own_done", int'(ack), 0);
    // Enable freeze stretches the watchdog window.
    do_reset();
    req = 3'b001;
    step();
    req = '0;
    step(); step();
    enb = 1'b0;
    repeat (4) step();
    chk("frz_hold", int'(ack), 3'b001);
    enb = 1'b1;
    wait_ack(1'b0);
    step();
    chk("frz_len", last_run, MAX_HOLD + 4);
    chk("frz_to", int'(timeout), 3'b001);
    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 3'b001;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ack", int'(ack), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    run = 0;
    req = 3'b110;
    wait_ack(1'b1);
    chk("arst_first", int'(grant_id), 1);
    req = '0; done = 3'b010;
    step();
    done = '0;
    // Randomized traffic checked by the scoreboard.
    repeat (2000) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      done = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      intrpt = ($urandom_range(0, 15) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      enb = $urandom_range(0, 7) != 0;
      err_clr = $urandom_range(0, 19) == 0;
      step();
    end
    req = '0; done = '0; intrpt = '0; enb = 1'b1; err_clr = 1'b0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
